mem_access_unit: RTL and testbench



---
 rtl/mau_pkg.sv | 33 +++
 rtl/byte_lane_unit.sv | 53 +++++
 rtl/mem_access_unit.sv | 112 +++++++++++
 tb/tb_mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states and
// the lane-offset helper used by both the FSM and the lane datapath.
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

  // Lane offset with the bits that a size cannot address forced to zero, so a
  // misaligned access that is allowed through lands on its natural lane.
  function automatic logic [1:0] lane_off(input size_e sz, input logic [1:0] a);
    logic [1:0] off;
    case (sz)
      SZ_BYTE: off = a;
      SZ_HALF: off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane steering: merges store data into a read word and extracts
// a right-justified, optionally sign-extended load value from a memory word.
module byte_lane_unit
  import mau_pkg::*;
(
  input  logic [31:0] rdbuf_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic        signed_i,
  output logic [31:0] merged_o,
  output logic [31:0] extract_o
);

  logic [4:0]  shift;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] shifted;

  assign shift = {off_i, 3'b000};

  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    case (size_i)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00FF << shift;
        lane_data = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        lane_mask = 32'h0000_FFFF << shift;
        lane_data = {2{wdata_i[15:0]}};
      end
      default: begin
        lane_mask = WORD_MASK;
        lane_data = wdata_i;
      end
    endcase
    merged_o = (rdbuf_i & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    shifted   = word_i >> shift;
    extract_o = word_i;
    case (size_i)
      SZ_BYTE: extract_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: extract_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: extract_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-wide data memory. Sub-word stores are done as
// read-modify-write; every accepted request gets exactly one response pulse.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mr,
  output logic [31:0]       mqb,
  output logic              mwmem,
  input  logic [31:0]       mdo
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  size_e             size_q;
  logic              we_q;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdbuf_q;
  logic              err_q;

  logic        accept;
  logic        misalign;
  logic        req_err;
  logic [1:0]  off;
  logic [31:0] merged;
  logic [31:0] extracted;

  assign accept   = req_valid & (state_q == ST_IDLE);
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign req_err  = (req_size == SZ_RSVD) || (ALIGN_CHECK && misalign);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_d = ST_RESP;
          else if (!req_we)            state_d = ST_RD;
          else if (req_size == SZ_WORD) state_d = ST_WR;
          else                         state_d = ST_RD;
        end
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) err_q <= req_err;
    end
  end

  // Request capture and read buffer carry data only, so they are not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= req_addr;
      size_q   <= size_e'(req_size);
      we_q     <= req_we;
      signed_q <= req_signed;
      wdata_q  <= req_wdata;
    end
    if (state_q == ST_RD) rdbuf_q <= mdo;
  end

  assign off = lane_off(size_q, addr_q[1:0]);

  byte_lane_unit u_lanes (
    .rdbuf_i  (rdbuf_q),
    .wdata_i  (wdata_q),
    .word_i   (rdbuf_q),
    .size_i   (size_q),
    .off_i    (off),
    .signed_i (signed_q),
    .merged_o (merged),
    .extract_o(extracted)
  );

  // All memory-side outputs decode from registered state, so mwmem is settled
  // well before the memory's negedge write strobe.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid & ~err_q & ~we_q) ? extracted : 32'h0;
  assign mr         = ((state_q == ST_RD) || (state_q == ST_WR)) ?
                      {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mqb        = (state_q == ST_WR) ? merged : 32'h0;
  assign mwmem      = (state_q == ST_WR) & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written reset and
// back-to-back sequences, then random traffic against a byte-array model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        va, vb;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr, wdata;

  logic        rdy_a, rv_a, er_a, mw_a;
  logic [31:0] rd_a, mr_a, mqb_a, mdo_a;
  logic        rdy_b, rv_b, er_b, mw_b;
  logic [31:0] rd_b, mr_b, mqb_b, mdo_b;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [7:0]  refb  [128];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(rdy_a), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(er_a),
    .mr(mr_a), .mqb(mqb_a), .mwmem(mw_a), .mdo(mdo_a)
  );

  mem_access_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rdy_b), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv_b), .resp_rdata(rd_b), .resp_err(er_b),
    .mr(mr_b), .mqb(mqb_b), .mwmem(mw_b), .mdo(mdo_b)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = (32'h9e3779b9 * 32'(i)) ^ 32'h5a5a0000;
    if (i == 20) v = 32'h000000a3;
    return v;
  endfunction

  assign mdo_a = mem_a[mr_a[6:2]];
  assign mdo_b = mem_b[mr_b[6:2]];

  initial begin
    for (int i = 0; i < 32; i++) mem_a[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (mw_a) mem_a[mr_a[6:2]] = mqb_a;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem_b[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (mw_b) mem_b[mr_b[6:2]] = mqb_b;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1);
  end

  // Reference model: memory as 128 bytes, little-endian.
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [6:0] b;
    b = {a[6:2], 2'b00};
    return {refb[b+3], refb[b+2], refb[b+1], refb[b]};
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic s, input logic [31:0] a);
    logic [31:0] v;
    logic [6:0]  b;
    b = a[6:0];
    if (sz == 2'd0) begin
      v = 32'(refb[b]);
      if (s && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = 32'(refb[b]) + 256 * 32'(refb[b+1]);
      if (s && v >= 32768) v = v - 65536;
    end else begin
      v = ref_word(a);
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [6:0] b;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    b = a[6:0];
    for (int i = 0; i < n; i++) refb[b + 7'(i)] = wd[8*i +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_req(input bit sel, input logic we_v, input logic [1:0] sz,
                        input logic sgn_v, input logic [31:0] ad, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nmw, output logic [31:0] mqb_seen);
    int w;
    @(negedge clk);
    we = we_v; size = sz; sgn = sgn_v; addr = ad; wdata = wd;
    if (sel) vb = 1'b1; else va = 1'b1;
    w = 0;
    while (!(sel ? rdy_b : rdy_a) && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    va = 1'b0; vb = 1'b0;
    rdata = '0; err = 1'b0; lat = 0; nmw = 0; mqb_seen = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sel ? mw_b : mw_a) begin
        nmw++;
        mqb_seen = sel ? mqb_b : mqb_a;
      end
      if (sel ? rv_b : rv_a) begin
        rdata = sel ? rd_b : rd_a;
        err   = sel ? er_b : er_a;
        lat   = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_mw;
    logic [31:0] exp_mqb;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] r_data, r_mqb;
  logic        r_err;
  int          r_lat, r_mw;
  logic [31:0] got_q [$];
  int          cyc_q [$];
  int          issued;
  bit          saw_resp;

  initial begin
    rst = 1'b1; va = 1'b0; vb = 1'b0;
    we = 1'b0; size = 2'd0; sgn = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 128; i++) refb[i] = 8'(init_word(i / 4) >> (8 * (i % 4)));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(rdy_a), 32'd1);
    chk("reset resp_valid", 32'(rv_a), 32'd0);
    chk("reset resp_err", 32'(er_a), 32'd0);
    chk("reset resp_rdata", rd_a, 32'h0);
    chk("reset mr", mr_a, 32'h0);
    chk("reset mqb", mqb_a, 32'h0);
    chk("reset mwmem", 32'(mw_a), 32'd0);
    rst = 1'b0;

    tbl[0] = '{1'b0, 2'd2, 1'b0, 32'h50, 32'h0,        32'h000000a3, 1'b0, 2, 0, 32'h0};
    tbl[1] = '{1'b1, 2'd0, 1'b0, 32'h51, 32'h000000ff, 32'h0,        1'b0, 3, 1, 32'h0000ffa3};
    tbl[2] = '{1'b0, 2'd0, 1'b1, 32'h51, 32'h0,        32'hffffffff, 1'b0, 2, 0, 32'h0};
    tbl[3] = '{1'b0, 2'd0, 1'b0, 32'h51, 32'h0,        32'h000000ff, 1'b0, 2, 0, 32'h0};
    tbl[4] = '{1'b0, 2'd1, 1'b0, 32'h50, 32'h0,        32'h0000ffa3, 1'b0, 2, 0, 32'h0};
    tbl[5] = '{1'b1, 2'd2, 1'b0, 32'h52, 32'hcafef00d, 32'h0,        1'b1, 1, 0, 32'h0};
    tbl[6] = '{1'b0, 2'd1, 1'b1, 32'h53, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
    tbl[7] = '{1'b0, 2'd3, 1'b0, 32'h54, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};

    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
             r_data, r_err, r_lat, r_mw, r_mqb);
      chk($sformatf("vec%0d latency", i), 32'(r_lat), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d rdata", i), r_data, tbl[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(r_err), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d mwmem pulses", i), 32'(r_mw), 32'(tbl[i].exp_mw));
      if (tbl[i].exp_mw != 0) chk($sformatf("vec%0d mqb", i), r_mqb, tbl[i].exp_mqb);
      if (tbl[i].we && !tbl[i].exp_err) ref_store(tbl[i].size, tbl[i].addr, tbl[i].wdata);
    end
    chk("word 0x50 after SB", mem_a[20], 32'h0000ffa3);
    chk("word 0x54 untouched by errors", mem_a[21], init_word(21));

    // Reset landing in the WR cycle of a halfword store must suppress the write.
    @(negedge clk);
    we = 1'b1; size = 2'd1; sgn = 1'b0; addr = 32'h56; wdata = 32'h00001234; va = 1'b1;
    @(posedge clk); #1; va = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rst-in-WR mr", mr_a, 32'h54);
    chk("rst-in-WR mwmem", 32'(mw_a), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst-in-WR req_ready", 32'(rdy_a), 32'd1);
    saw_resp = rv_a;
    repeat (4) begin
      @(negedge clk);
      if (rv_a) saw_resp = 1'b1;
    end
    chk("rst-in-WR no resp_valid", 32'(saw_resp), 32'd0);
    chk("rst-in-WR word 0x54", mem_a[21], init_word(21));

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h50; va = 1'b1;
    issued = 0;
    for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
      if (rv_a) begin
        got_q.push_back(rd_a);
        cyc_q.push_back(c);
      end
      if (rdy_a && va) begin
        issued++;
        @(posedge clk); #1;
        if (issued < 4) addr = 32'h50 + 32'(4 * issued);
        else va = 1'b0;
      end
      @(negedge clk);
    end
    va = 1'b0;
    chk("b2b response count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < got_q.size(); i++) begin
      chk($sformatf("b2b data %0d", i), got_q[i], ref_word(32'h50 + 32'(4 * i)));
      if (i > 0) chk($sformatf("b2b spacing %0d", i), 32'(cyc_q[i] - cyc_q[i-1]), 32'd3);
    end

    // Unit with alignment checking disabled.
    do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h52, 32'hdeadbeef, r_data, r_err, r_lat, r_mw, r_mqb);
    chk("noalign SW err", 32'(r_err), 32'd0);
    chk("noalign SW latency", 32'(r_lat), 32'd2);
    chk("noalign SW mwmem pulses", 32'(r_mw), 32'd1);
    chk("noalign word 0x50", mem_b[20], 32'hdeadbeef);
    do_req(1'b1, 1'b0, 2'd1, 1'b1, 32'h53, 32'h0, r_data, r_err, r_lat, r_mw, r_mqb);
    chk("noalign LH rdata", r_data, 32'hffffdead);
    chk("noalign LH err", 32'(r_err), 32'd0);
    do_req(1'b1, 1'b0, 2'd3, 1'b0, 32'h54, 32'h0, r_data, r_err, r_lat, r_mw, r_mqb);
    chk("noalign size11 err", 32'(r_err), 32'd1);
    chk("noalign size11 latency", 32'(r_lat), 32'd1);

    // Random traffic against the byte-array model.
    for (int n = 0; n < 150; n++) begin
      logic        rw, rs, e_err;
      logic [1:0]  rsz;
      logic [31:0] ra, rwd, e_data;
      int          e_lat;
      rw  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      rsz = 2'($urandom_range(0, 3));
      ra  = 32'($urandom_range(0, 127));
      rwd = $urandom;
      e_err  = ref_err(rsz, ra);
      e_data = (!rw && !e_err) ? ref_load(rsz, rs, ra) : 32'h0;
      e_lat  = e_err ? 1 : (!rw ? 2 : (rsz == 2'd2 ? 2 : 3));
      do_req(1'b0, rw, rsz, rs, ra, rwd, r_data, r_err, r_lat, r_mw, r_mqb);
      chk($sformatf("rnd%0d latency", n), 32'(r_lat), 32'(e_lat));
      chk($sformatf("rnd%0d rdata", n), r_data, e_data);
      chk($sformatf("rnd%0d err", n), 32'(r_err), 32'(e_err));
      chk($sformatf("rnd%0d mwmem pulses", n), 32'(r_mw), (rw && !e_err) ? 32'd1 : 32'd0);
      if (rw && !e_err) begin
        ref_store(rsz, ra, rwd);
        chk($sformatf("rnd%0d mqb", n), r_mqb, ref_word(ra));
        chk($sformatf("rnd%0d memory", n), mem_a[ra[6:2]], ref_word(ra));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
